// File: rtl/wb_arbiter_pkg.sv
// Shared register-file definitions for the write-back stage and reg_file.
// Holds the register index/data widths, the register count, the hardwired
// zero register index, and the load-return FIFO entry layout.
package wb_arbiter_pkg;

  localparam int IDX_W    = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << IDX_W;

  localparam logic [IDX_W-1:0] REG_ZERO = '0;

  // One buffered load return. A set squash bit means a younger ALU write
  // already committed to the same register, so this entry must not be written.
  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
    logic              squash;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-return FIFO for the write-back arbiter.
// Ports:
//   clk, rst             clock, async active-low reset (empties the FIFO)
//   push/push_index/data write a new entry at the tail (caller checks not full)
//   pop                  drop the head entry (caller checks not empty)
//   squash_en/index      mark every entry with a matching index as squashed,
//                        including the entry being pushed in the same cycle
//   count                number of valid entries, 0..DEPTH
//   head                 entry at the read pointer
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_index,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              squash_en,
  input  logic [IDX_W-1:0]  squash_index,
  output logic [CNT_W-1:0]  count,
  output wb_entry_t         head
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Stale (invalid) slots may get squashed too; harmless, a push overwrites them.
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && (mem[i].index == squash_index)) mem[i].squash <= 1'b1;
      end
      // The tail write comes last so it wins over the broadcast for that slot.
      if (push) begin
        mem[wr_ptr] <= '{index:  push_index,
                         data:   push_data,
                         squash: squash_en && (squash_index == push_index)};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the reg_file write port.
// Merges single-cycle ALU results with buffered load returns, keeps in-order
// register semantics via squash bits, never writes r0, and bounds load
// starvation by stalling the ALU for one cycle after STARVE_LIMIT bypasses.
// Ports:
//   clk, rst                         clock, async active-low reset
//   alu_wr_en/index/data             ALU result (ignored while alu_stall=1)
//   mem_valid/wr_index/wr_data       load return, accepted when mem_ready=1
//   mem_ready                        FIFO not full (registered count)
//   alu_stall                        upstream must hold its ALU result
//   wr_en/wr_reg_index/wr_reg_data   registered write port to reg_file
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wr_en,
  input  logic [IDX_W-1:0]  alu_wr_index,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [IDX_W-1:0]  mem_wr_index,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              alu_stall,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_reg_index,
  output logic [DATA_W-1:0] wr_reg_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] count;
  wb_entry_t        head;
  logic [STV_W-1:0] starve_cnt;
  logic             fifo_empty;
  logic             alu_sel;
  logic             push;
  logic             pop;

  assign fifo_empty = (count == '0);
  assign mem_ready  = (count < CNT_W'(DEPTH));
  assign alu_stall  = (starve_cnt >= STV_W'(STARVE_LIMIT));
  assign alu_sel    = alu_wr_en & ~alu_stall;
  assign push       = mem_valid & mem_ready;
  // Stall implies a non-empty FIFO, so the head always drains on a stall cycle.
  assign pop        = ~alu_sel & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_index   (mem_wr_index),
    .push_data    (mem_wr_data),
    .pop          (pop),
    .squash_en    (alu_sel),
    .squash_index (alu_wr_index),
    .count        (count),
    .head         (head)
  );

  // Counter cannot pass STARVE_LIMIT: reaching it forces a pop next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (alu_sel) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_reg_index <= '0;
      wr_reg_data  <= '0;
    end else if (alu_sel) begin
      wr_en        <= (alu_wr_index != REG_ZERO);
      wr_reg_index <= alu_wr_index;
      wr_reg_data  <= alu_wr_data;
    end else if (pop) begin
      wr_en        <= ~head.squash && (head.index != REG_ZERO);
      wr_reg_index <= head.index;
      wr_reg_data  <= head.data;
    end else begin
      wr_en        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wr_en;
  logic [3:0]  alu_wr_index;
  logic [31:0] alu_wr_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wr_index;
  logic [31:0] mem_wr_data;
  logic        alu_stall;
  logic        wr_en;
  logic [3:0]  wr_reg_index;
  logic [31:0] wr_reg_data;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wr_en    (alu_wr_en),
    .alu_wr_index (alu_wr_index),
    .alu_wr_data  (alu_wr_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wr_index (mem_wr_index),
    .mem_wr_data  (mem_wr_data),
    .alu_stall    (alu_stall),
    .wr_en        (wr_en),
    .wr_reg_index (wr_reg_index),
    .wr_reg_data  (wr_reg_data)
  );

  always #5 clk = ~clk;

  // Bench register file fed by the DUT write port (stores r0 too, so a bad r0 write shows).
  bit [31:0] regs [16];
  bit        r0_written;
  always @(posedge clk) begin
    if (wr_en) begin
      regs[wr_reg_index] <= wr_reg_data;
      if (wr_reg_index == 4'd0) r0_written <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queue of pending loads, an age counter for the head, and the expected write.
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    bit          sq;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          exp_en;
  logic [3:0]  exp_idx;
  logic [31:0] exp_data;
  bit          m_sel, m_push, m_busy;
  ent_t        m_e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      starve   = 0;
      exp_en   = 0;
      exp_idx  = 0;
      exp_data = 0;
    end else begin
      m_sel  = alu_wr_en && (starve < LIMIT);
      m_push = mem_valid && (q.size() < DEPTH);
      m_busy = (q.size() > 0);
      if (m_sel) begin
        foreach (q[i]) if (q[i].idx == alu_wr_index) q[i].sq = 1;
        exp_en   = (alu_wr_index != 0);
        exp_idx  = alu_wr_index;
        exp_data = alu_wr_data;
      end else if (m_busy) begin
        m_e      = q.pop_front();
        exp_en   = !m_e.sq && (m_e.idx != 0);
        exp_idx  = m_e.idx;
        exp_data = m_e.data;
      end else begin
        exp_en = 0;
      end
      starve = (m_busy && m_sel) ? starve + 1 : 0;
      if (m_push) begin
        m_e.idx  = mem_wr_index;
        m_e.data = mem_wr_data;
        m_e.sq   = m_sel && (alu_wr_index == mem_wr_index);
        q.push_back(m_e);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("cyc_wr_en", wr_en, exp_en);
      check("cyc_alu_stall", alu_stall, starve >= LIMIT);
      check("cyc_mem_ready", mem_ready, q.size() < DEPTH);
      if (exp_en) begin
        check("cyc_wr_index", wr_reg_index, exp_idx);
        check("cyc_wr_data", wr_reg_data, exp_data);
      end
    end
  end

  task automatic step(input bit ae, input logic [3:0] ai, input logic [31:0] ad,
                      input bit mv, input logic [3:0] mi, input logic [31:0] md);
    alu_wr_en    = ae;
    alu_wr_index = ai;
    alu_wr_data  = ad;
    mem_valid    = mv;
    mem_wr_index = mi;
    mem_wr_data  = md;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_wr_en = 0;
    mem_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 0;
    alu_wr_en = 0; alu_wr_index = 0; alu_wr_data = 0;
    mem_valid = 0; mem_wr_index = 0; mem_wr_data = 0;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_index", wr_reg_index, 0);
    check("rst_wr_data", wr_reg_data, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_stall", alu_stall, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    idle(1);

    // 1: ALU only
    step(1, 5, 1234, 0, 0, 0);
    check("s1_wr_en", wr_en, 1);
    check("s1_wr_index", wr_reg_index, 5);
    check("s1_wr_data", wr_reg_data, 1234);
    idle(1);
    check("s1_r5", regs[5], 1234);

    // 2: load only, one cycle in the FIFO then written
    check("s2_mem_ready", mem_ready, 1);
    step(0, 0, 0, 1, 7, 99);
    check("s2_wr_en_early", wr_en, 0);
    idle(1);
    check("s2_wr_en", wr_en, 1);
    check("s2_wr_index", wr_reg_index, 7);
    idle(1);
    check("s2_r7", regs[7], 99);

    // 3: starvation
    step(0, 0, 0, 1, 3, 11);
    step(1, 1, 101, 0, 0, 0);
    step(1, 2, 102, 0, 0, 0);
    step(1, 4, 104, 0, 0, 0);
    check("s3_stall_on", alu_stall, 1);
    step(1, 6, 106, 0, 0, 0);
    check("s3_stall_off", alu_stall, 0);
    check("s3_drain_index", wr_reg_index, 3);
    check("s3_drain_data", wr_reg_data, 11);
    step(1, 6, 106, 0, 0, 0);
    idle(2);
    check("s3_r3", regs[3], 11);
    check("s3_r4", regs[4], 104);
    check("s3_r6", regs[6], 106);

    // 4a: buffered load squashed by a younger ALU write
    step(0, 0, 0, 1, 9, 5);
    step(1, 9, 77, 0, 0, 0);
    idle(1);
    check("s4_squash_wr_en", wr_en, 0);
    idle(2);
    check("s4a_r9", regs[9], 77);
    // 4b: load push and ALU write to the same index in one cycle
    step(1, 9, 1, 0, 0, 0);
    step(1, 9, 77, 1, 9, 5);
    idle(3);
    check("s4b_r9", regs[9], 77);

    // 5: fill FIFO while ALU busy; first load targets r0
    step(1, 1, 201, 1, 0, 2431);
    step(1, 2, 202, 1, 11, 21);
    step(1, 4, 204, 1, 12, 22);
    step(1, 6, 206, 1, 13, 23);
    check("s5_full_ready", mem_ready, 0);
    check("s5_full_stall", alu_stall, 1);
    step(0, 0, 0, 1, 8, 55);
    check("s5_r0_wr_en", wr_en, 0);
    idle(6);
    step(0, 0, 0, 1, 8, 55);
    idle(3);
    check("s5_r8", regs[8], 55);
    check("s5_r11", regs[11], 21);
    check("s5_r13", regs[13], 23);
    check("s5_r0", regs[0], 0);
    check("s5_r0_written", r0_written, 0);

    // 6: reset with three loads buffered
    step(1, 1, 301, 1, 11, 401);
    step(1, 2, 302, 1, 12, 402);
    step(1, 4, 304, 1, 13, 403);
    alu_wr_en = 0;
    mem_valid = 0;
    rst = 0;
    #1;
    check("s6_wr_en", wr_en, 0);
    check("s6_wr_index", wr_reg_index, 0);
    check("s6_wr_data", wr_reg_data, 0);
    check("s6_mem_ready", mem_ready, 1);
    check("s6_alu_stall", alu_stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    idle(6);
    check("s6_r11", regs[11], 21);
    check("s6_r12", regs[12], 22);
    check("s6_r13", regs[13], 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
